arbiter: RTL and testbench
==========================

Name: arbiter

Overview:
- Four-requester round-robin arbiter producing a registered one-hot grant vector.
- Sits between four independent requesting agents and a single shared resource; exactly one agent owns the resource at a time.
- Grant is held while the owner keeps requesting; on release, ownership rotates fairly to the next requester.

Parameters:
- None. Requester count is fixed at 4 and grant width at 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- REQUEST1  input  1  request from agent 1 (level, active-high)
- REQUEST2  input  1  request from agent 2
- REQUEST3  input  1  request from agent 3
- REQUEST4  input  1  request from agent 4
- GRANT_O  output  4  one-hot grant, registered; bit0 = agent 1, bit1 = agent 2, bit2 = agent 3, bit3 = agent 4; 4'b0000 = no grant

Behaviour:
- One clock (clk); reset is asynchronous and active-high.
- Reset asserted: GRANT_O = 4'b0000 immediately, independent of clk. Priority pointer = "last granted = agent 4", so agent 1 has highest priority first.
- Reset deasserted: normal operation from the next rising clk edge.
- Requests are sampled on the rising clk edge. GRANT_O updates on that same edge, so latency from a request to its grant is 1 cycle.
- GRANT_O is always one-hot or all-zero; never more than one bit set.
- Idle state (GRANT_O = 0):
  - If any request is high, grant the first requesting agent in circular order starting after the last-granted agent.
  - If no request is high, stay at 0000.
- Busy state (agent k granted):
  - REQUESTk still high: hold the grant on agent k (no preemption), regardless of other requests.
  - REQUESTk low and some other request high: at that edge, move the grant directly to the next requester in circular order after k. No idle cycle between owners.
  - REQUESTk low and no requests high: GRANT_O -> 0000, and the pointer remembers k.
- Circular order is 1 -> 2 -> 3 -> 4 -> 1.
- The pointer updates only when a new grant is issued. It is unchanged while idle and while holding.
- Simultaneous requests: the winner is decided purely by the rotating pointer. No agent may be granted twice in a row while another agent has been requesting continuously since before the first of those grants.
- X/Z on request inputs is out of scope. Requests are assumed stable around the rising edge.
- Implementation: a small FSM (IDLE, GNT1..GNT4) or a pointer register plus grant register. Purely synchronous apart from the async reset.

Test Plan:
- Reset: assert reset mid-grant with GRANT_O = 0010 -> GRANT_O = 0000 immediately, before any clock edge. After release with requests 1,1,1,1 -> first edge gives GRANT_O = 0001.
- Single requester: REQUEST3 = 1, others 0, for 3 cycles -> GRANT_O = 0100 from the first edge and held. Then REQUEST3 = 0 -> GRANT_O = 0000 on the next edge.
- Hold/no preemption: agent 2 granted (0010). Raise REQUEST1 and REQUEST4 while REQUEST2 stays high -> GRANT_O remains 0010 every cycle.
- Rotation: all four requests held high, each owner drops its request for one cycle after being granted -> grant sequence 0001, 0010, 0100, 1000, 0001, with no 0000 cycles in between.
- Pointer memory: grant agent 3, then all requests low (GRANT_O = 0000). Then raise REQUEST1 and REQUEST4 together -> GRANT_O = 1000 (agent 4 follows 3), not 0001.
- Wrap: agent 4 granted. Drop REQUEST4 while REQUEST1 and REQUEST3 are high -> GRANT_O = 0001 on that edge.

Source files
------------

// File: rtl/arbiter_if.sv
// Request/grant bundle between the four agents and the round-robin arbiter.
interface arbiter_if;
    logic       REQUEST1;
    logic       REQUEST2;
    logic       REQUEST3;
    logic       REQUEST4;
    logic [3:0] GRANT_O;

    modport master (output REQUEST1, REQUEST2, REQUEST3, REQUEST4, input GRANT_O);
    modport slave  (input REQUEST1, REQUEST2, REQUEST3, REQUEST4, output GRANT_O);
endinterface

// File: rtl/arbiter.sv
// Four-requester round-robin arbiter with a registered one-hot grant and
// hold-while-requested ownership.
module arbiter (
    input  logic      clk,
    input  logic      reset,
    arbiter_if.slave  bus
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0] req;
    logic [NUM_LANES-1:0] grant_q, grant_nxt;
    logic [1:0]           ptr_q, ptr_nxt;
    logic [1:0]           idx;
    logic                 found;

    assign req = {bus.REQUEST4, bus.REQUEST3, bus.REQUEST2, bus.REQUEST1};

    // The owner keeps the grant while it requests. Otherwise scan circularly
    // starting after the last-granted agent; that agent itself is checked last.
    always_comb begin
        grant_nxt = grant_q;
        ptr_nxt   = ptr_q;
        found     = 1'b0;
        idx       = '0;
        if (~|(grant_q & req)) begin
            grant_nxt = '0;
            for (int i = 1; i <= NUM_LANES; i++) begin
                idx = ptr_q + 2'(i);
                if (!found && req[idx]) begin
                    found          = 1'b1;
                    grant_nxt[idx] = 1'b1;
                    ptr_nxt        = idx;
                end
            end
        end
    end

    // Pointer starts at agent 4 so agent 1 wins the first arbitration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q <= '0;
            ptr_q   <= 2'd3;
        end else begin
            grant_q <= grant_nxt;
            ptr_q   <= ptr_nxt;
        end
    end

    assign bus.GRANT_O = grant_q;
endmodule

// File: tb/tb_arbiter.sv
// Directed bench for the round-robin arbiter: reset, hold, rotation,
// pointer memory and wrap-around.
module tb_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    arbiter_if bus ();

    arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // r[0] = agent 1 ... r[3] = agent 4
    task automatic drive(input logic [3:0] r);
        bus.REQUEST1 = r[0];
        bus.REQUEST2 = r[1];
        bus.REQUEST3 = r[2];
        bus.REQUEST4 = r[3];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] exp);
        checks++;
        assert (bus.GRANT_O === exp)
        else begin
            errors++;
            $error("FAIL %s: GRANT_O got %b expected %b", tag, bus.GRANT_O, exp);
        end
    endtask

    task automatic step(input logic [3:0] r, input string tag, input logic [3:0] exp);
        drive(r);
        tick();
        chk(tag, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(4'b0000);
        tick();
        tick();
        chk("reset_state", 4'b0000);

        // first arbitration after reset goes to agent 1
        reset = 1'b0;
        step(4'b1111, "first_after_reset", 4'b0001);
        step(4'b1110, "handoff_1_to_2",    4'b0010);

        // async reset mid-grant, checked before the next edge
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", 4'b0000);
        #1;
        reset = 1'b0;
        step(4'b1111, "release_all_req", 4'b0001);

        // single requester
        step(4'b0000, "release_to_idle", 4'b0000);
        step(4'b0100, "single_r3_a", 4'b0100);
        step(4'b0100, "single_r3_b", 4'b0100);
        step(4'b0100, "single_r3_c", 4'b0100);
        step(4'b0000, "single_r3_off", 4'b0000);

        // hold: agent 2 keeps ownership while others pile on
        step(4'b0010, "grant_r2",  4'b0010);
        step(4'b1011, "hold_r2_a", 4'b0010);
        step(4'b1011, "hold_r2_b", 4'b0010);
        step(4'b1011, "hold_r2_c", 4'b0010);

        // rotation from a fresh pointer
        reset = 1'b1;
        #2;
        chk("reset_again", 4'b0000);
        reset = 1'b0;
        step(4'b1111, "rot_1",  4'b0001);
        step(4'b1110, "rot_2",  4'b0010);
        step(4'b1101, "rot_3",  4'b0100);
        step(4'b1011, "rot_4",  4'b1000);
        step(4'b0111, "rot_5",  4'b0001);
        step(4'b1111, "rot_hold", 4'b0001);

        // pointer memory: after agent 3, agent 4 beats agent 1
        step(4'b0100, "mem_grant_r3", 4'b0100);
        step(4'b0000, "mem_idle",     4'b0000);
        step(4'b0000, "mem_idle_2",   4'b0000);
        step(4'b1001, "mem_r4_wins",  4'b1000);

        // wrap 4 -> 1, skipping agent 3
        step(4'b0101, "wrap_4_to_1", 4'b0001);

        // sole requester may be re-granted after idle
        step(4'b0000, "regrant_idle", 4'b0000);
        step(4'b0001, "regrant_r1",   4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
